// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative MULT/MULTU/DIV/DIVU unit owning HI/LO, one step per cycle
module ex_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
    state_t state, state_nx;
    logic [CW-1:0] count;
    logic [2*WIDTH-1:0] acc, acc_nx, prod;
    logic [WIDTH-1:0] opb, quo, rem, res_hi, res_lo;
    logic [WIDTH:0] add_sum, shl, sub_rem;
    logic is_div, neg_a, neg_b, q_bit, sgn;
    // state register
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    // next-state: flush wins, CALC runs WIDTH steps, FIX lasts one cycle
    always_comb
        state_nx = flush ? IDLE :
                   state == IDLE ? (start ? CALC : IDLE) :
                   state == CALC ? (count == CW'(WIDTH-1) ? FIX : CALC) : IDLE;
    // outputs decoded from state
    always_comb busy = state != IDLE;
    // one iteration: shift-add for multiply, restoring shift-subtract for divide
    always_comb begin
        add_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, acc[0] ? opb : '0};
        shl     = acc[2*WIDTH-1:WIDTH-1];
        q_bit   = shl >= {1'b0, opb};
        sub_rem = q_bit ? shl - {1'b0, opb} : shl;
        acc_nx  = is_div ? {sub_rem[WIDTH-1:0], acc[WIDTH-2:0], q_bit} : {add_sum, acc[WIDTH-1:1]};
    end
    // sign correction; a zero divisor forces an all-ones quotient, remainder is the dividend
    always_comb begin
        sgn    = neg_a ^ neg_b;
        prod   = sgn ? -acc : acc;
        quo    = acc[WIDTH-1:0];
        rem    = acc[2*WIDTH-1:WIDTH];
        res_lo = is_div ? (opb == '0 ? '1 : (sgn ? -quo : quo)) : prod[WIDTH-1:0];
        res_hi = is_div ? (neg_a ? -rem : rem) : prod[2*WIDTH-1:WIDTH];
    end
    // operand latch at start and iteration datapath
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            acc    <= '0;
            opb    <= '0;
            count  <= '0;
            is_div <= 1'b0;
            neg_a  <= 1'b0;
            neg_b  <= 1'b0;
        end else if (state == IDLE && start && !flush) begin
            acc    <= {{WIDTH{1'b0}}, (!op[0] && rs_val[WIDTH-1]) ? -rs_val : rs_val};
            opb    <= (!op[0] && rt_val[WIDTH-1]) ? -rt_val : rt_val;
            count  <= '0;
            is_div <= op[1];
            neg_a  <= !op[0] && rs_val[WIDTH-1];
            neg_b  <= !op[0] && rt_val[WIDTH-1];
        end else if (state == CALC && !flush) begin
            acc   <= acc_nx;
            count <= count + 1'b1;
        end
    // HI/LO writes: op result at FIX, mthi/mtlo only while idle, nothing on flush
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            hi   <= '0;
            lo   <= '0;
            done <= 1'b0;
        end else begin
            done <= state == FIX && !flush;
            if (state == FIX && !flush) begin
                hi <= res_hi;
                lo <= res_lo;
            end else if (state == IDLE && !flush) begin
                if (mthi) hi <= rs_val;
                if (mtlo) lo <= rs_val;
            end
        end
endmodule
